fetch_queue: RTL and testbench

Two-wide instruction queue between the fetch stage and decode. It accepts the two-packet bundle that fetch emits (`{packet_b, packet_a}`), stores packets in program order, and presents up to two oldest packets per cycle to decode. Consumed slots are released individually. The queue decouples fetch-side stalls (cache misses, two-cycle partial fetches) from decode backpressure and drains in one cycle on a pipeline flush.

---
 rtl/fetch_queue_pkg.sv | 13 +
 rtl/fq_storage.sv | 40 ++++
 rtl/fetch_queue.sv | 84 ++++++++
 tb/tb_fetch_queue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
// The queue treats packets as opaque vectors; fetched_packet_t documents their layout.
package fetch_queue_pkg;

  localparam int STATS_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [30:0] data;
    logic        taken_branch;
  } fetched_packet_t;

endpackage

// File: rtl/fq_storage.sv
// Circular packet array with two write ports and two read ports.
// The second port of each pair addresses the entry after the first, wrapping modulo DEPTH.
module fq_storage
  import fetch_queue_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata_a,
  input  logic [WIDTH-1:0] wdata_b,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    waddr_b;
  logic [AW-1:0]    raddr_b;

  // DEPTH is a power of two, so plain AW-bit addition wraps for free.
  assign waddr_b = waddr + AW'(1);
  assign raddr_b = raddr + AW'(1);

  // NOTE: the array has no reset; only the pointers define which entries are live,
  // and resetting storage would add a reset fan-out to every bit for no benefit.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr]   <= wdata_a;
      mem[waddr_b] <= wdata_b;
    end
  end

  assign rdata_a = mem[raddr];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/fetch_queue.sv
// Two-wide in-order queue between fetch and decode: bundle push, per-slot in-order pop,
// single-cycle flush, plus full-stall and empty-cycle statistics.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int PACKET_SIZE = 64,
  parameter int DEPTH       = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2*PACKET_SIZE-1:0] data_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic                     must_flush,
  output logic [2*PACKET_SIZE-1:0] data_out,
  output logic [1:0]               valid_o,
  input  logic [1:0]               ready_in,
  output logic [CW-1:0]            occupancy,
  output logic [STATS_W-1:0]       full_stalls,
  output logic [STATS_W-1:0]       empty_cycles
);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop0;
  logic          pop1;

  // Space is judged from the registered count only; a same-cycle pop is credited next cycle.
  assign ready_out = (count <= CW'(DEPTH - 2));
  assign valid_o[0] = (count != '0) && !must_flush;
  assign valid_o[1] = (count >= CW'(2)) && !must_flush;
  assign occupancy  = count;

  assign push = valid_in & ready_out & ~must_flush;
  assign pop0 = valid_o[0] & ready_in[0];
  assign pop1 = pop0 & valid_o[1] & ready_in[1];

  fq_storage #(
    .WIDTH (PACKET_SIZE),
    .DEPTH (DEPTH)
  ) u_storage (
    .clk     (clk),
    .we      (push),
    .waddr   (wr_ptr),
    .wdata_a (data_in[PACKET_SIZE-1:0]),
    .wdata_b (data_in[2*PACKET_SIZE-1:PACKET_SIZE]),
    .raddr   (rd_ptr),
    .rdata_a (data_out[PACKET_SIZE-1:0]),
    .rdata_b (data_out[2*PACKET_SIZE-1:PACKET_SIZE])
  );

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (must_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(2);
      rd_ptr <= rd_ptr + AW'(pop0) + AW'(pop1);
      count  <= count + CW'({push, 1'b0}) - CW'(pop0) - CW'(pop1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_stalls  <= '0;
      empty_cycles <= '0;
    end else begin
      if (valid_in && !ready_out) full_stalls  <= full_stalls + STATS_W'(1);
      if (count == '0)            empty_cycles <= empty_cycles + STATS_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int PS    = 64;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2*PS-1:0]   data_in;
  logic              valid_in;
  logic              ready_out;
  logic              must_flush;
  logic [2*PS-1:0]   data_out;
  logic [1:0]        valid_o;
  logic [1:0]        ready_in;
  logic [CW-1:0]     occupancy;
  logic [63:0]       full_stalls;
  logic [63:0]       empty_cycles;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  logic [PS-1:0] q[$];
  longint unsigned m_full  = 0;
  longint unsigned m_empty = 0;

  always #5 clk = ~clk;

  fetch_queue #(.PACKET_SIZE(PS), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .must_flush   (must_flush),
    .data_out     (data_out),
    .valid_o      (valid_o),
    .ready_in     (ready_in),
    .occupancy    (occupancy),
    .full_stalls  (full_stalls),
    .empty_cycles (empty_cycles)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PS-1:0] pkt(input logic [31:0] pc);
    fetched_packet_t p;
    p.pc           = pc;
    p.data         = 31'($urandom);
    p.taken_branch = pc[3];
    return p;
  endfunction

  function automatic logic [31:0] pc_of(input logic [PS-1:0] x);
    fetched_packet_t p;
    p = fetched_packet_t'(x);
    return p.pc;
  endfunction

  // Reference behaviour: an in-order list of packets, bounded by DEPTH.
  function automatic void model_step();
    int  sz;
    bit  can_take;
    int  npop;
    sz       = q.size();
    can_take = (DEPTH - sz) >= 2;
    if (valid_in && !can_take) m_full++;
    if (sz == 0) m_empty++;
    if (must_flush) begin
      q.delete();
    end else begin
      npop = 0;
      if (ready_in[0] && sz >= 1) npop = (ready_in[1] && sz >= 2) ? 2 : 1;
      for (int i = 0; i < npop; i++) void'(q.pop_front());
      if (valid_in && can_take) begin
        q.push_back(data_in[PS-1:0]);
        q.push_back(data_in[2*PS-1:PS]);
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_full  = 0;
      m_empty = 0;
    end else begin
      model_step();
    end
  end

  // Single compare process, mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      int sz;
      sz = q.size();
      check("valid_o", 64'(valid_o),
            64'({(sz >= 2) && !must_flush, (sz >= 1) && !must_flush}));
      check("ready_out", 64'(ready_out), 64'((DEPTH - sz) >= 2));
      check("occupancy", 64'(occupancy), 64'(sz));
      check("full_stalls", full_stalls, m_full);
      check("empty_cycles", empty_cycles, m_empty);
      if (sz >= 1 && !must_flush) check("slot0", data_out[PS-1:0], q[0]);
      if (sz >= 2 && !must_flush) check("slot1", data_out[2*PS-1:PS], q[1]);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic [31:0] pc_a);
    data_in = {pkt(pc_a + 32'd4), pkt(pc_a)};
  endtask

  initial begin
    logic [63:0] base;
    logic [31:0] next_pc;
    rst_n      = 1'b0;
    valid_in   = 1'b0;
    ready_in   = 2'b00;
    must_flush = 1'b0;
    data_in    = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Reset then idle
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_ready_out", 64'(ready_out), 64'd1);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    base = empty_cycles;
    repeat (10) cycle();
    check("idle_empty_delta", empty_cycles - base, 64'd10);

    // Fill with decode stalled
    for (int i = 0; i < 4; i++) begin
      set_bundle(32'(8 * i));
      valid_in = 1'b1;
      cycle();
    end
    check("full_occupancy", 64'(occupancy), 64'd8);
    check("full_ready_out", 64'(ready_out), 64'd0);
    base = full_stalls;
    cycle();
    valid_in = 1'b0;
    check("full_stall_delta", full_stalls - base, 64'd1);
    check("full_slot0_pc", 64'(pc_of(data_out[PS-1:0])), 64'h0);

    // Partial drain
    ready_in = 2'b01; cycle(); ready_in = 2'b00;
    check("drain01_occ", 64'(occupancy), 64'd7);
    check("drain01_pc", 64'(pc_of(data_out[PS-1:0])), 64'h4);
    ready_in = 2'b10; cycle(); ready_in = 2'b00;
    check("drain10_occ", 64'(occupancy), 64'd7);
    check("drain10_pc", 64'(pc_of(data_out[PS-1:0])), 64'h4);
    ready_in = 2'b11; cycle(); ready_in = 2'b00;
    check("drain11_occ", 64'(occupancy), 64'd5);
    check("drain11_pc", 64'(pc_of(data_out[PS-1:0])), 64'hC);

    // Simultaneous push and pop across the pointer wrap
    ready_in = 2'b01; cycle(); ready_in = 2'b00;
    set_bundle(32'h20); valid_in = 1'b1; cycle(); valid_in = 1'b0;
    check("pre_sim_occ", 64'(occupancy), 64'd6);
    check("pre_sim_ready", 64'(ready_out), 64'd1);
    set_bundle(32'h28); valid_in = 1'b1; ready_in = 2'b11; cycle();
    valid_in = 1'b0; ready_in = 2'b00;
    check("sim_occ", 64'(occupancy), 64'd6);
    check("sim_slot0_pc", 64'(pc_of(data_out[PS-1:0])), 64'h18);
    ready_in = 2'b11; cycle(); ready_in = 2'b00;
    check("wrap_slot0_pc", 64'(pc_of(data_out[PS-1:0])), 64'h20);
    check("wrap_slot1_pc", 64'(pc_of(data_out[2*PS-1:PS])), 64'h24);
    check("wrap_occ", 64'(occupancy), 64'd4);

    // Flush with concurrent push and pop
    set_bundle(32'h30); valid_in = 1'b1; ready_in = 2'b11; must_flush = 1'b1;
    #1 check("flush_valid_o", 64'(valid_o), 64'd0);
    cycle();
    must_flush = 1'b0; valid_in = 1'b0; ready_in = 2'b00;
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_valid_after", 64'(valid_o), 64'd0);
    set_bundle(32'h100); valid_in = 1'b1; cycle(); valid_in = 1'b0;
    check("post_flush_pc", 64'(pc_of(data_out[PS-1:0])), 64'h100);
    check("post_flush_occ", 64'(occupancy), 64'd2);

    // Asynchronous reset mid-stream
    set_bundle(32'h108); valid_in = 1'b1; ready_in = 2'b01; cycle();
    valid_in = 1'b0; ready_in = 2'b00;
    check("pre_rst_occ", 64'(occupancy), 64'd3);
    #1 rst_n = 1'b0;
    #1 check("async_rst_valid_o", 64'(valid_o), 64'd0);
    check("async_rst_occ", 64'(occupancy), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_rst_ready", 64'(ready_out), 64'd1);
    check("post_rst_occ", 64'(occupancy), 64'd0);

    // Randomized traffic against the model
    next_pc = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      set_bundle(next_pc);
      next_pc    = next_pc + 32'd8;
      valid_in   = ($urandom_range(3) != 0);
      ready_in   = 2'($urandom);
      must_flush = ($urandom_range(49) == 0);
      cycle();
    end
    valid_in = 1'b0; ready_in = 2'b11; must_flush = 1'b0;
    repeat (6) cycle();
    check("final_occ", 64'(occupancy), 64'd0);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
